// File: rtl/seg_scan_if.sv
// Value-producer to display-driver handshake: one packed hex word plus a per-digit blank mask.
// The producer holds in_valid and its payload until it sees in_ready.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*NUM_DIGITS-1:0] in_data;
  logic [NUM_DIGITS-1:0]   in_blank_mask;

  modport master (output in_valid, output in_data, output in_blank_mask, input in_ready);
  modport slave  (input in_valid, input in_data, input in_blank_mask, output in_ready);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned value updates,
// per-digit blanking and leading-zero blanking.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_if.slave             in_if,
  input  logic                  lzb_en,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_DARK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = SEG_DARK;
    endcase
    return seg;
  endfunction

  // Index of the most significant nonzero digit; 0 when every digit is zero.
  function automatic logic [IW-1:0] find_msnz(input logic [DW-1:0] digits);
    logic [IW-1:0] pos;
    pos = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      pos = (digits[4*k +: 4] != 4'h0) ? IW'(k) : pos;
    end
    return pos;
  endfunction

  logic [PW-1:0]         presc_r;
  logic [IW-1:0]         idx_r;
  logic [DW-1:0]         disp_r;
  logic [NUM_DIGITS-1:0] disp_mask_r;
  logic [DW-1:0]         pend_data_r;
  logic [NUM_DIGITS-1:0] pend_mask_r;
  logic                  pend_r;
  logic                  ready_r;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;

  logic                  tick_s;
  logic [IW-1:0]         idx_nx_s;
  logic                  frame_s;
  logic                  apply_s;
  logic                  accept_s;
  logic                  pend_nx_s;
  logic [DW-1:0]         disp_nx_s;
  logic [NUM_DIGITS-1:0] mask_nx_s;
  logic [IW-1:0]         msnz_s;
  logic [3:0]            digit_s;
  logic                  mask_bit_s;
  logic                  dark_s;
  logic [6:0]            seg_nx_s;
  logic [NUM_DIGITS-1:0] an_nx_s;

  // Scan timing, handshake and display-value selection for the coming slot.
  always_comb begin
    tick_s    = (presc_r == PRE_LAST);
    idx_nx_s  = (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
    frame_s   = tick_s & (idx_nx_s == '0);
    apply_s   = frame_s & pend_r;
    accept_s  = in_if.in_valid & ready_r;
    disp_nx_s = apply_s ? pend_data_r : disp_r;
    mask_nx_s = apply_s ? pend_mask_r : disp_mask_r;
    if (apply_s) begin
      pend_nx_s = 1'b0;
    end else if (accept_s) begin
      pend_nx_s = 1'b1;
    end else begin
      pend_nx_s = pend_r;
    end
  end

  // Decode of the digit that becomes visible at the next tick, using the value live after it.
  always_comb begin
    msnz_s     = find_msnz(disp_nx_s);
    digit_s    = 4'h0;
    mask_bit_s = 1'b0;
    an_nx_s    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_s    = (idx_nx_s == IW'(k)) ? disp_nx_s[4*k +: 4] : digit_s;
      mask_bit_s = (idx_nx_s == IW'(k)) ? mask_nx_s[k] : mask_bit_s;
      an_nx_s[k] = (idx_nx_s == IW'(k)) ? 1'b0 : 1'b1;
    end
    // Digit 0 can never exceed msnz, so LZB leaves it lit.
    dark_s   = mask_bit_s | (lzb_en & (idx_nx_s > msnz_s));
    seg_nx_s = dark_s ? SEG_DARK : hex_to_seg(digit_s);
  end

  // Prescaler, scan index and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= IDX_LAST;
      seg_r   <= SEG_DARK;
      an_r    <= '1;
    end else if (tick_s) begin
      presc_r <= '0;
      idx_r   <= idx_nx_s;
      seg_r   <= seg_nx_s;
      an_r    <= an_nx_s;
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  // Pending slot, displayed value and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_r <= '0;
      pend_mask_r <= '0;
      pend_r      <= 1'b0;
      ready_r     <= 1'b1;
      disp_r      <= '0;
      disp_mask_r <= '0;
    end else begin
      if (accept_s) begin
        pend_data_r <= in_if.in_data;
        pend_mask_r <= in_if.in_blank_mask;
      end
      pend_r      <= pend_nx_s;
      ready_r     <= ~pend_nx_s;
      disp_r      <= disp_nx_s;
      disp_mask_r <= mask_nx_s;
    end
  end

  assign seg_n          = seg_r;
  assign an_n           = an_r;
  assign in_if.in_ready = ready_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit / SCAN_DIV=4 instance plus a 1-digit / SCAN_DIV=1 instance.
module tb_seg_scan_driver;

  logic       clk;
  logic       rst_n;
  logic       lzb_en;
  logic [6:0] seg_n;
  logic [3:0] an_n;

  logic       rst_n1;
  logic       lzb_en1;
  logic [6:0] seg_n1;
  logic [0:0] an_n1;

  int errors;
  int checks;

  seg_scan_if #(.NUM_DIGITS(4)) u_if ();
  seg_scan_if #(.NUM_DIGITS(1)) u_if1 ();

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (u_if.slave),
    .lzb_en (lzb_en),
    .seg_n  (seg_n),
    .an_n   (an_n)
  );

  seg_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n1),
    .in_if  (u_if1.slave),
    .lzb_en (lzb_en1),
    .seg_n  (seg_n1),
    .an_n   (an_n1)
  );

  always #5 clk = ~clk;

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after the release point; the next rising edge is cycle 1.
  task automatic do_reset;
    rst_n = 1'b0;
    u_if.in_valid = 1'b0;
    step_n(1);
    rst_n = 1'b1;
  endtask

  task automatic drive_load(input logic [15:0] data, input logic [3:0] mask);
    u_if.in_valid = 1'b1;
    u_if.in_data = data;
    u_if.in_blank_mask = mask;
    step_n(1);
    u_if.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] exp_an;
    do_reset;
    for (int i = 1; i <= 3; i++) begin
      step_n(1);
      checks++;
      if (seg_n !== 7'h7F || an_n !== 4'b1111 || u_if.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: seg_n=%b an_n=%b ready=%b required 1111111/1111/1", i, seg_n, an_n, u_if.in_ready);
      end
    end
    step_n(1);
    checks++;
    if (seg_n !== 7'b0000001 || an_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_first_tick: seg_n=%b an_n=%b required 0000001/1110", seg_n, an_n);
    end
    for (int d = 1; d < 4; d++) begin
      step_n(3);
      exp_an = 4'b0001 << (d - 1);
      exp_an = ~exp_an;
      checks++;
      if (an_n !== exp_an) begin
        errors++;
        $display("FAIL reset_hold d%0d: an_n=%b required %b", d, an_n, exp_an);
      end
      step_n(1);
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      checks++;
      if (an_n !== exp_an || seg_n !== 7'b0000001) begin
        errors++;
        $display("FAIL reset_rotate d%0d: an_n=%b seg_n=%b required %b/0000001", d, an_n, seg_n, exp_an);
      end
    end
  endtask

  task automatic test_load_midframe;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = 7'b0111000;
    exp_seg[1] = 7'b0001000;
    exp_seg[2] = 7'b0010010;
    exp_seg[3] = 7'b1001111;
    lzb_en = 1'b0;
    do_reset;
    step_n(6);
    drive_load(16'h12AF, 4'b0000);
    checks++;
    if (u_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_low: ready=%b required 0", u_if.in_ready);
    end
    step_n(1);
    checks++;
    if (an_n !== 4'b1101 || seg_n !== 7'b0000001) begin
      errors++;
      $display("FAIL load_old_value: an_n=%b seg_n=%b required 1101/0000001", an_n, seg_n);
    end
    step_n(11);
    checks++;
    if (u_if.in_ready !== 1'b0 || an_n !== 4'b0111 || seg_n !== 7'b0000001) begin
      errors++;
      $display("FAIL load_before_boundary: ready=%b an_n=%b seg_n=%b required 0/0111/0000001", u_if.in_ready, an_n, seg_n);
    end
    step_n(1);
    checks++;
    if (u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_back: ready=%b required 1", u_if.in_ready);
    end
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step_n(4);
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg[d]) begin
        errors++;
        $display("FAIL load_12AF d%0d: an_n=%b seg_n=%b required %b/%b", d, an_n, seg_n, exp_an, exp_seg[d]);
      end
    end
  endtask

  task automatic test_lzb;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = 7'b0000001;
    exp_seg[1] = 7'b0000110;
    exp_seg[2] = 7'h7F;
    exp_seg[3] = 7'h7F;
    do_reset;
    lzb_en = 1'b1;
    step_n(6);
    drive_load(16'h0030, 4'b0000);
    step_n(13);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step_n(4);
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg[d]) begin
        errors++;
        $display("FAIL lzb_0030 d%0d: an_n=%b seg_n=%b required %b/%b", d, an_n, seg_n, exp_an, exp_seg[d]);
      end
    end
    drive_load(16'h0000, 4'b0000);
    step_n(3);
    exp_seg[1] = 7'h7F;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step_n(4);
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg[d]) begin
        errors++;
        $display("FAIL lzb_0000 d%0d: an_n=%b seg_n=%b required %b/%b", d, an_n, seg_n, exp_an, exp_seg[d]);
      end
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_mask;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = 7'h7F;
    exp_seg[1] = 7'b0000000;
    exp_seg[2] = 7'h7F;
    exp_seg[3] = 7'b0000000;
    do_reset;
    step_n(6);
    drive_load(16'h8888, 4'b0101);
    step_n(13);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step_n(4);
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg[d]) begin
        errors++;
        $display("FAIL mask_8888 d%0d: an_n=%b seg_n=%b required %b/%b", d, an_n, seg_n, exp_an, exp_seg[d]);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    step_n(6);
    u_if.in_valid = 1'b1;
    u_if.in_data = 16'h1111;
    u_if.in_blank_mask = 4'b0000;
    step_n(1);
    u_if.in_data = 16'h2222;
    for (int c = 8; c <= 19; c++) begin
      step_n(1);
      checks++;
      if (u_if.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_held cyc%0d: ready=%b required 0", c, u_if.in_ready);
      end
    end
    step_n(1);
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b1001111 || u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_applied: an_n=%b seg_n=%b ready=%b required 1110/1001111/1", an_n, seg_n, u_if.in_ready);
    end
    step_n(1);
    u_if.in_valid = 1'b0;
    checks++;
    if (u_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: ready=%b required 0", u_if.in_ready);
    end
    step_n(3);
    checks++;
    if (an_n !== 4'b1101 || seg_n !== 7'b1001111) begin
      errors++;
      $display("FAIL b2b_first_frame: an_n=%b seg_n=%b required 1101/1001111", an_n, seg_n);
    end
    step_n(12);
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b0010010 || u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_applied: an_n=%b seg_n=%b ready=%b required 1110/0010010/1", an_n, seg_n, u_if.in_ready);
    end
  endtask

  task automatic test_boundary_accept;
    do_reset;
    step_n(19);
    drive_load(16'h5555, 4'b0000);
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b0000001 || u_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bnd_not_applied: an_n=%b seg_n=%b ready=%b required 1110/0000001/0", an_n, seg_n, u_if.in_ready);
    end
    step_n(12);
    checks++;
    if (an_n !== 4'b0111 || seg_n !== 7'b0000001 || u_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bnd_still_old: an_n=%b seg_n=%b ready=%b required 0111/0000001/0", an_n, seg_n, u_if.in_ready);
    end
    step_n(4);
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b0100100 || u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bnd_next_frame: an_n=%b seg_n=%b ready=%b required 1110/0100100/1", an_n, seg_n, u_if.in_ready);
    end
  endtask

  task automatic test_reset_midframe;
    do_reset;
    step_n(6);
    drive_load(16'hABCD, 4'b0000);
    step_n(5);
    checks++;
    if (u_if.in_ready !== 1'b0 || an_n !== 4'b1011) begin
      errors++;
      $display("FAIL midrst_pending: ready=%b an_n=%b required 0/1011", u_if.in_ready, an_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_n !== 7'h7F || an_n !== 4'b1111 || u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_immediate: seg_n=%b an_n=%b ready=%b required 1111111/1111/1", seg_n, an_n, u_if.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_n(4);
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b0000001) begin
      errors++;
      $display("FAIL midrst_first_tick: an_n=%b seg_n=%b required 1110/0000001", an_n, seg_n);
    end
    step_n(16);
    checks++;
    if (an_n !== 4'b1110 || seg_n !== 7'b0000001 || u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_dropped: an_n=%b seg_n=%b ready=%b required 1110/0000001/1", an_n, seg_n, u_if.in_ready);
    end
  endtask

  task automatic test_single_digit;
    step_n(1);
    rst_n1 = 1'b1;
    step_n(1);
    checks++;
    if (an_n1 !== 1'b0 || seg_n1 !== 7'b0000001 || u_if1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_first_tick: an_n=%b seg_n=%b ready=%b required 0/0000001/1", an_n1, seg_n1, u_if1.in_ready);
    end
    u_if1.in_valid = 1'b1;
    u_if1.in_data = 4'h7;
    u_if1.in_blank_mask = 1'b0;
    step_n(1);
    u_if1.in_valid = 1'b0;
    checks++;
    if (seg_n1 !== 7'b0000001 || u_if1.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: seg_n=%b ready=%b required 0000001/0", seg_n1, u_if1.in_ready);
    end
    step_n(1);
    checks++;
    if (seg_n1 !== 7'b0001111 || u_if1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_apply: seg_n=%b ready=%b required 0001111/1", seg_n1, u_if1.in_ready);
    end
    u_if1.in_valid = 1'b1;
    u_if1.in_data = 4'h9;
    step_n(1);
    u_if1.in_valid = 1'b0;
    #2;
    rst_n1 = 1'b0;
    #1;
    checks++;
    if (seg_n1 !== 7'h7F || an_n1 !== 1'b1 || u_if1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_rst_immediate: seg_n=%b an_n=%b ready=%b required 1111111/1/1", seg_n1, an_n1, u_if1.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n1 = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      step_n(1);
      checks++;
      if (an_n1 !== 1'b0 || seg_n1 !== 7'b0000001) begin
        errors++;
        $display("FAIL single_rst_dropped cyc%0d: an_n=%b seg_n=%b required 0/0000001", c, an_n1, seg_n1);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    rst_n1 = 1'b0;
    lzb_en = 1'b0;
    lzb_en1 = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data = 16'h0000;
    u_if.in_blank_mask = 4'b0000;
    u_if1.in_valid = 1'b0;
    u_if1.in_data = 4'h0;
    u_if1.in_blank_mask = 1'b0;
    step_n(2);
    test_reset;
    test_load_midframe;
    test_lzb;
    test_mask;
    test_back_to_back;
    test_boundary_accept;
    test_reset_midframe;
    test_single_digit;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
